sap1_useq: RTL and testbench

Vertical microprogrammed sequencer for the 8-bit SAP-1 CPU. It steps a micro-PC through a 32-word microprogram ROM and decodes each vertical micro-word into the datapath control lines: PC, MAR, SRAM, IR, accumulator, adder/subtractor, B and output registers. Every instruction is a fixed six-state fetch/execute sequence. The block sits between the instruction register and the datapath and replaces hardwired ring-counter control.

---
 rtl/sap1_uop_pkg.sv | 60 ++++++
 rtl/sap1_urom.sv | 37 +++
 rtl/sap1_useq.sv | 138 +++++++++++++
 tb/tb_sap1_useq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_uop_pkg.sv
// Shared definitions for the SAP-1 vertical microprogram: micro-op and
// sequencing encodings, opcode values and microprogram entry addresses.
package sap1_uop_pkg;

    localparam int UWORD_W = 6;

    typedef enum logic [3:0] {
        UOP_NOP      = 4'd0,
        UOP_EP_LM    = 4'd1,
        UOP_CP       = 4'd2,
        UOP_CE_LI    = 4'd3,
        UOP_EI_LM    = 4'd4,
        UOP_CE_LA    = 4'd5,
        UOP_CE_LB    = 4'd6,
        UOP_EU_LA    = 4'd7,
        UOP_EU_SU_LA = 4'd8,
        UOP_EA_LO    = 4'd9
    } uop_t;

    typedef enum logic [1:0] {
        SEQ_INC = 2'd0,
        SEQ_MAP = 2'd1,
        SEQ_END = 2'd2,
        SEQ_HLT = 2'd3
    } seq_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [4:0] ENTRY_LDA   = 5'd3;
    localparam logic [4:0] ENTRY_ADD   = 5'd6;
    localparam logic [4:0] ENTRY_SUB   = 5'd9;
    localparam logic [4:0] ENTRY_OUT   = 5'd12;
    localparam logic [4:0] ENTRY_HLT   = 5'd15;
    localparam logic [4:0] ENTRY_UNDEF = 5'd16;

    // Packs a micro-op and its sequencing field into one ROM word.
    function automatic logic [UWORD_W-1:0] uword(input uop_t u, input seq_t s);
        return {u, s};
    endfunction

    // Maps an opcode to the first micro-word of its execute routine;
    // anything unrecognised runs the three-NOP filler routine.
    function automatic logic [4:0] entryOf(input logic [3:0] op);
        logic [4:0] addr;
        case (op)
            OP_LDA:  addr = ENTRY_LDA;
            OP_ADD:  addr = ENTRY_ADD;
            OP_SUB:  addr = ENTRY_SUB;
            OP_OUT:  addr = ENTRY_OUT;
            OP_HLT:  addr = ENTRY_HLT;
            default: addr = ENTRY_UNDEF;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/sap1_urom.sv
// Combinational 32 x 6 microprogram ROM. Each word is {uop, seq}; the
// microprogram lives here alone so it can be reworked independently.
module sap1_urom
    import sap1_uop_pkg::*;
(
    input  logic [4:0]         upc_i,
    output logic [UWORD_W-1:0] uword_o
);

    // Microprogram contents; unused addresses fall back to NOP/END.
    always_comb begin
        uword_o = uword(UOP_NOP, SEQ_END);
        case (upc_i)
            5'd0:  uword_o = uword(UOP_EP_LM,    SEQ_INC);
            5'd1:  uword_o = uword(UOP_CP,       SEQ_INC);
            5'd2:  uword_o = uword(UOP_CE_LI,    SEQ_MAP);
            5'd3:  uword_o = uword(UOP_EI_LM,    SEQ_INC);
            5'd4:  uword_o = uword(UOP_CE_LA,    SEQ_INC);
            5'd5:  uword_o = uword(UOP_NOP,      SEQ_END);
            5'd6:  uword_o = uword(UOP_EI_LM,    SEQ_INC);
            5'd7:  uword_o = uword(UOP_CE_LB,    SEQ_INC);
            5'd8:  uword_o = uword(UOP_EU_LA,    SEQ_END);
            5'd9:  uword_o = uword(UOP_EI_LM,    SEQ_INC);
            5'd10: uword_o = uword(UOP_CE_LB,    SEQ_INC);
            5'd11: uword_o = uword(UOP_EU_SU_LA, SEQ_END);
            5'd12: uword_o = uword(UOP_EA_LO,    SEQ_INC);
            5'd13: uword_o = uword(UOP_NOP,      SEQ_INC);
            5'd14: uword_o = uword(UOP_NOP,      SEQ_END);
            5'd15: uword_o = uword(UOP_NOP,      SEQ_HLT);
            5'd16: uword_o = uword(UOP_NOP,      SEQ_INC);
            5'd17: uword_o = uword(UOP_NOP,      SEQ_INC);
            5'd18: uword_o = uword(UOP_NOP,      SEQ_END);
            default: uword_o = uword(UOP_NOP, SEQ_END);
        endcase
    end

endmodule

// File: rtl/sap1_useq.sv
// SAP-1 microprogrammed sequencer: IDLE/RUN/HALT control FSM, micro-PC
// with opcode entry mapping, T-state counter and micro-op decoder.
module sap1_useq
    import sap1_uop_pkg::*;
#(
    parameter int UPC_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       bus_op,
    output logic             cp,
    output logic             ep,
    output logic             lm,
    output logic             ce,
    output logic             li,
    output logic             ei,
    output logic             la,
    output logic             ea,
    output logic             su,
    output logic             eu,
    output logic             lb,
    output logic             lo,
    output logic             halted,
    output logic             instr_done,
    output logic [5:0]       ring,
    output logic [UPC_W-1:0] upc_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [UPC_W-1:0]   upc_q, upc_d;
    logic [2:0]         tcnt_q, tcnt_d;
    logic [UWORD_W-1:0] curWord;
    uop_t               curUop;
    seq_t               curSeq;

    sap1_urom u_rom (
        .upc_i   (upc_q[4:0]),
        .uword_o (curWord)
    );

    assign curUop = uop_t'(curWord[5:2]);
    assign curSeq = seq_t'(curWord[1:0]);

    // State, micro-PC and T-state registers; reset aborts instantly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next state: the micro-word's seq field steers the micro-PC; run is
    // only looked at on END words and in IDLE.
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                upc_d  = '0;
                tcnt_d = '0;
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                case (curSeq)
                    SEQ_INC: begin
                        upc_d  = upc_q + UPC_W'(1);
                        tcnt_d = tcnt_q + 3'd1;
                    end
                    SEQ_MAP: begin
                        upc_d  = UPC_W'(entryOf(bus_op));
                        tcnt_d = tcnt_q + 3'd1;
                    end
                    SEQ_END: begin
                        upc_d  = '0;
                        tcnt_d = '0;
                        if (!run) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        upc_d   = '0;
                        tcnt_d  = '0;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_HALT: begin
                upc_d  = '0;
                tcnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                upc_d   = '0;
                tcnt_d  = '0;
            end
        endcase
    end

    // Micro-op decoder; control lines are live only while running.
    always_comb begin
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
        if (state_q == ST_RUN) begin
            case (curUop)
                UOP_EP_LM:    begin ep = 1'b1; lm = 1'b1; end
                UOP_CP:       cp = 1'b1;
                UOP_CE_LI:    begin ce = 1'b1; li = 1'b1; end
                UOP_EI_LM:    begin ei = 1'b1; lm = 1'b1; end
                UOP_CE_LA:    begin ce = 1'b1; la = 1'b1; end
                UOP_CE_LB:    begin ce = 1'b1; lb = 1'b1; end
                UOP_EU_LA:    begin eu = 1'b1; la = 1'b1; end
                UOP_EU_SU_LA: begin eu = 1'b1; su = 1'b1; la = 1'b1; end
                UOP_EA_LO:    begin ea = 1'b1; lo = 1'b1; end
                default:      ;
            endcase
        end
    end

    assign ring       = (state_q == ST_RUN) ? (6'b000001 << tcnt_q) : 6'b000000;
    assign instr_done = (state_q == ST_RUN) && (curSeq == SEQ_END);
    assign halted     = (state_q == ST_HALT);
    assign upc_o      = upc_q;

endmodule

// File: tb/tb_sap1_useq.sv
// Directed bench for sap1_useq: walks LDA, ADD, SUB, OUT, HLT, an
// undefined opcode, run drop-out and mid-instruction reset.
module tb_sap1_useq;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] bus_op;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic       halted;
    logic       instr_done;
    logic [5:0] ring;
    logic [4:0] upc;
    logic [11:0] ctrl;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] C_NONE     = 12'h000;
    localparam logic [11:0] C_EP_LM    = 12'h600;
    localparam logic [11:0] C_CP       = 12'h800;
    localparam logic [11:0] C_CE_LI    = 12'h180;
    localparam logic [11:0] C_EI_LM    = 12'h240;
    localparam logic [11:0] C_CE_LA    = 12'h120;
    localparam logic [11:0] C_CE_LB    = 12'h102;
    localparam logic [11:0] C_EU_LA    = 12'h024;
    localparam logic [11:0] C_EU_SU_LA = 12'h02C;
    localparam logic [11:0] C_EA_LO    = 12'h011;

    sap1_useq #(.UPC_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .bus_op     (bus_op),
        .cp         (cp),
        .ep         (ep),
        .lm         (lm),
        .ce         (ce),
        .li         (li),
        .ei         (ei),
        .la         (la),
        .ea         (ea),
        .su         (su),
        .eu         (eu),
        .lb         (lb),
        .lo         (lo),
        .halted     (halted),
        .instr_done (instr_done),
        .ring       (ring),
        .upc_o      (upc)
    );

    assign ctrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

    // Free-running 10 ns clock; rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives the level inputs; called only at falling edges.
    task automatic applyStimulus(input logic runVal, input logic [3:0] opVal);
        run    = runVal;
        bus_op = opVal;
    endtask

    // Advances one clock and lands on the following falling edge.
    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compares all control lines, ring, instr_done and halted at once.
    task automatic checkOutput(input string tag, input logic [11:0] expCtrl,
                               input logic [5:0] expRing, input logic expDone,
                               input logic expHalted);
        checks++;
        assert ({ctrl, ring, instr_done, halted} === {expCtrl, expRing, expDone, expHalted})
        else begin
            errors++;
            $error("[TB] FAIL %s: got ctrl=%h ring=%b done=%b halted=%b, want ctrl=%h ring=%b done=%b halted=%b",
                   tag, ctrl, ring, instr_done, halted, expCtrl, expRing, expDone, expHalted);
        end
    endtask

    // Compares the debug micro-PC.
    task automatic checkUpc(input string tag, input logic [4:0] expUpc);
        checks++;
        assert (upc === expUpc)
        else begin
            errors++;
            $error("[TB] FAIL %s: got upc=%0d, want upc=%0d", tag, upc, expUpc);
        end
    endtask

    // Fetch cycles T1-T3 are identical for every instruction.
    task automatic checkFetch(input string tag);
        nextCycle();
        checkOutput({tag, "_T1"}, C_EP_LM, 6'b000001, 1'b0, 1'b0);
        nextCycle();
        checkOutput({tag, "_T2"}, C_CP, 6'b000010, 1'b0, 1'b0);
        nextCycle();
        checkOutput({tag, "_T3"}, C_CE_LI, 6'b000100, 1'b0, 1'b0);
    endtask

    // Directed scenario sequence.
    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("reset", C_NONE, 6'b0, 1'b0, 1'b0);
        checkUpc("reset_upc", 5'd0);

        $display("[TB] LDA from reset");
        rst = 1'b1;
        applyStimulus(1'b1, 4'b0000);
        checkFetch("lda");
        nextCycle();
        checkOutput("lda_T4", C_EI_LM, 6'b001000, 1'b0, 1'b0);
        checkUpc("lda_T4_upc", 5'd3);
        nextCycle();
        checkOutput("lda_T5", C_CE_LA, 6'b010000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("lda_T6", C_NONE, 6'b100000, 1'b1, 1'b0);

        $display("[TB] ADD then SUB back-to-back");
        applyStimulus(1'b1, 4'b0001);
        checkFetch("add");
        nextCycle();
        checkOutput("add_T4", C_EI_LM, 6'b001000, 1'b0, 1'b0);
        checkUpc("add_T4_upc", 5'd6);
        applyStimulus(1'b1, 4'b1111);
        nextCycle();
        checkOutput("add_T5_late_op", C_CE_LB, 6'b010000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("add_T6", C_EU_LA, 6'b100000, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b0010);
        checkFetch("sub");
        nextCycle();
        checkOutput("sub_T4", C_EI_LM, 6'b001000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sub_T5", C_CE_LB, 6'b010000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sub_T6", C_EU_SU_LA, 6'b100000, 1'b1, 1'b0);

        $display("[TB] OUT then HLT");
        applyStimulus(1'b1, 4'b1110);
        checkFetch("out");
        nextCycle();
        checkOutput("out_T4", C_EA_LO, 6'b001000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("out_T5", C_NONE, 6'b010000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("out_T6", C_NONE, 6'b100000, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b1111);
        checkFetch("hlt");
        nextCycle();
        checkOutput("hlt_T4", C_NONE, 6'b001000, 1'b0, 1'b0);
        checkUpc("hlt_T4_upc", 5'd15);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            checkOutput("halted_hold", C_NONE, 6'b0, 1'b0, 1'b1);
        end

        $display("[TB] reset out of HALT, undefined opcode");
        rst = 1'b0;
        #1;
        checkOutput("halt_reset", C_NONE, 6'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 4'b0101);
        checkFetch("undef");
        nextCycle();
        checkOutput("undef_T4", C_NONE, 6'b001000, 1'b0, 1'b0);
        checkUpc("undef_T4_upc", 5'd16);
        nextCycle();
        checkOutput("undef_T5", C_NONE, 6'b010000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("undef_T6", C_NONE, 6'b100000, 1'b1, 1'b0);
        checkUpc("undef_T6_upc", 5'd18);

        $display("[TB] run dropped during T2");
        applyStimulus(1'b1, 4'b0000);
        nextCycle();
        checkOutput("drop_T1", C_EP_LM, 6'b000001, 1'b0, 1'b0);
        nextCycle();
        checkOutput("drop_T2", C_CP, 6'b000010, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        nextCycle();
        checkOutput("drop_T3", C_CE_LI, 6'b000100, 1'b0, 1'b0);
        nextCycle();
        checkOutput("drop_T4", C_EI_LM, 6'b001000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("drop_T5", C_CE_LA, 6'b010000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("drop_T6", C_NONE, 6'b100000, 1'b1, 1'b0);
        nextCycle();
        checkOutput("idle_1", C_NONE, 6'b0, 1'b0, 1'b0);
        checkUpc("idle_upc", 5'd0);
        nextCycle();
        checkOutput("idle_2", C_NONE, 6'b0, 1'b0, 1'b0);

        $display("[TB] restart, then reset during ADD T5");
        applyStimulus(1'b1, 4'b0001);
        checkFetch("restart");
        nextCycle();
        checkOutput("radd_T4", C_EI_LM, 6'b001000, 1'b0, 1'b0);
        nextCycle();
        checkOutput("radd_T5", C_CE_LB, 6'b010000, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset", C_NONE, 6'b0, 1'b0, 1'b0);
        checkUpc("midreset_upc", 5'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 4'b0000);
        nextCycle();
        checkOutput("post_reset_T1", C_EP_LM, 6'b000001, 1'b0, 1'b0);
        checkUpc("post_reset_upc", 5'd0);
        nextCycle();
        checkOutput("post_reset_T2", C_CP, 6'b000010, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
